// File: rtl/seq_run_ctrl.sv
// Run controller for a 6-bit up/down sequence generator: prescaled stepping,
// ascending/descending phase tracking, cycle counting and optional auto-stop.
module seq_run_ctrl #(
    parameter int DIV_W = 8,
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [DIV_W-1:0] div,
    input  logic [CYC_W-1:0] num_cycles,
    input  logic [5:0]       gen_out,
    output logic             gen_en,
    output logic             gen_clr,
    output logic             phase,
    output logic [CYC_W-1:0] cyc_cnt,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; cyc_cnt/phase hold last run's result
    // CLEAR | one-cycle generator clear, prescaler loaded
    // RUN   | prescaler counting down, gen_en on terminal count
    // PAUSE | stepping frozen, prescaler value held
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc_nxt;
    logic [CYC_W-1:0] num_q;
    logic [CYC_W-1:0] cyc_inc;
    logic             at_top;
    logic             wrap_end;
    logic             complete;

    // gen_en is registered, so it is raised on the edge that takes the prescaler to 0
    always_comb begin
        presc_nxt = (presc == '0) ? div_q : presc - 1'b1;
        cyc_inc   = cyc_cnt + 1'b1;
        at_top    = (gen_out == 6'd63);
        wrap_end  = phase && (gen_out == 6'd0);
        complete  = wrap_end && (num_q != '0) && (cyc_inc == num_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= '0;
            div_q   <= '0;
            num_q   <= '0;
            gen_en  <= 1'b0;
            gen_clr <= 1'b0;
            phase   <= 1'b0;
            cyc_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            gen_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    gen_en <= 1'b0;
                    busy   <= 1'b0;
                    if (start && !stop) begin
                        state   <= CLEAR;
                        div_q   <= div;
                        num_q   <= num_cycles;
                        cyc_cnt <= '0;
                        phase   <= 1'b0;
                        gen_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        gen_en <= 1'b0;
                    end else begin
                        state  <= RUN;
                        presc  <= div_q;
                        gen_en <= (div_q == '0);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        gen_en <= 1'b0;
                    end else begin
                        if (!phase && at_top) begin
                            phase <= 1'b1;
                        end else if (wrap_end) begin
                            phase   <= 1'b0;
                            cyc_cnt <= cyc_inc;
                        end
                        if (complete) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            gen_en <= 1'b0;
                        end else if (pause) begin
                            state  <= PAUSE;
                            gen_en <= 1'b0;
                        end else begin
                            presc  <= presc_nxt;
                            gen_en <= (presc_nxt == '0);
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        gen_en <= 1'b0;
                    end else if (!pause) begin
                        // the release edge counts as a normal RUN step
                        state  <= RUN;
                        presc  <= presc_nxt;
                        gen_en <= (presc_nxt == '0);
                    end else begin
                        gen_en <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    gen_en <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    gen_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench for seq_run_ctrl: scoreboard of per-cycle control outputs,
// table of forced generator values, and hand-written corner sequences.
module tb_seq_run_ctrl;

    localparam int DIV_W = 8;
    localparam int CYC_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic [DIV_W-1:0] div;
    logic [CYC_W-1:0] num_cycles;
    logic [5:0]       gen_out;
    logic             gen_en;
    logic             gen_clr;
    logic             phase;
    logic [CYC_W-1:0] cyc_cnt;
    logic             busy;
    logic             done;

    seq_run_ctrl #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .div        (div),
        .num_cycles (num_cycles),
        .gen_out    (gen_out),
        .gen_en     (gen_en),
        .gen_clr    (gen_clr),
        .phase      (phase),
        .cyc_cnt    (cyc_cnt),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: 0..63 ascending, then back down to 0, repeating
    logic [5:0] gen_q;
    logic       gen_up;
    logic       gen_force;
    logic [5:0] gen_force_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_q  <= 6'd0;
            gen_up <= 1'b1;
        end else if (gen_clr) begin
            gen_q  <= 6'd0;
            gen_up <= 1'b1;
        end else if (gen_en) begin
            if (gen_up) begin
                if (gen_q == 6'd63) begin
                    gen_up <= 1'b0;
                    gen_q  <= 6'd62;
                end else begin
                    gen_q <= gen_q + 6'd1;
                end
            end else begin
                if (gen_q == 6'd0) begin
                    gen_up <= 1'b1;
                    gen_q  <= 6'd1;
                end else begin
                    gen_q <= gen_q - 6'd1;
                end
            end
        end
    end

    assign gen_out = gen_force ? gen_force_val : gen_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard entries: {gen_en, gen_clr, busy, done} expected one per cycle
    typedef struct {
        string      name;
        logic [3:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    task automatic push(input string nm, input logic [3:0] c);
        exp_t e2;
        e2.name = nm;
        e2.ctl  = c;
        sb_q.push_back(e2);
    endtask

    always @(posedge clk) begin
        #1;
        if (done) done_seen++;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check(sb_e.name, 32'({gen_en, gen_clr, busy, done}), 32'(sb_e.ctl));
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic fstep(input logic [5:0] v);
        @(negedge clk);
        gen_force_val = v;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]       gout;
        logic             ph;
        logic [CYC_W-1:0] cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ks;
        int done_cyc;
        int toggles;
        int viol;
        int done_before;
        logic prev_ph;
        logic en_b;
        logic clr_b;

        tbl[0] = '{6'd0,  1'b0, 4'd0};
        tbl[1] = '{6'd63, 1'b1, 4'd0};
        tbl[2] = '{6'd63, 1'b1, 4'd0};
        tbl[3] = '{6'd5,  1'b1, 4'd0};
        tbl[4] = '{6'd0,  1'b0, 4'd1};
        tbl[5] = '{6'd0,  1'b0, 4'd1};
        tbl[6] = '{6'd63, 1'b1, 4'd1};
        tbl[7] = '{6'd0,  1'b0, 4'd2};

        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        div = '0;
        num_cycles = '0;
        gen_force = 1'b0;
        gen_force_val = 6'd0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({gen_en, gen_clr, phase, cyc_cnt, busy, done}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 32'({gen_en, gen_clr, busy, done}), 32'd0);

        // div=3 free-run: clear at k+1, steps at k+5, k+9, k+13; a mid-run start is ignored
        done_before = done_seen;
        div = 8'd3;
        num_cycles = 4'd0;
        start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            en_b  = (n >= 5) && (((n - 5) % 4) == 0);
            clr_b = (n == 1);
            push("run_div3", {en_b, clr_b, 1'b1, 1'b0});
        end
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 6) begin
                start = 1'b1;
                div = 8'd0;
                num_cycles = 4'd1;
            end
        end
        drain();
        stop = 1'b1;
        for (int n = 0; n < 3; n++) push("stop_run", 4'b0000);
        @(negedge clk);
        stop = 1'b0;
        drain();
        check("no_done_on_stop", 32'(done_seen - done_before), 32'd0);

        // start together with stop in IDLE is rejected
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        push("start_stop_idle", 4'b0000);
        push("start_stop_idle", 4'b0000);
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        drain();

        // pause for 10 cycles starting 2 cycles after a step
        @(negedge clk);
        div = 8'd3;
        num_cycles = 4'd0;
        start = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            en_b  = (n == 5) || (n == 19) || (n == 23);
            clr_b = (n == 1);
            push("pause_run", {en_b, clr_b, 1'b1, 1'b0});
        end
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 7) pause = 1'b1;
            if (n == 17) pause = 1'b0;
        end
        drain();
        stop = 1'b1;
        push("stop_pause", 4'b0000);
        @(negedge clk);
        stop = 1'b0;
        drain();

        // div=0, two full cycles against the generator model
        done_before = done_seen;
        @(negedge clk);
        div = 8'd0;
        num_cycles = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        ks = cyc;
        start = 1'b0;
        prev_ph = phase;
        toggles = 0;
        done_cyc = -1;
        for (int i = 0; i < 400 && done_cyc < 0; i++) begin
            @(posedge clk);
            #1;
            if (phase != prev_ph) toggles++;
            prev_ph = phase;
            if (done) begin
                done_cyc = cyc;
                check("done_cyc_cnt", 32'(cyc_cnt), 32'd2);
                check("done_busy_gen_en", 32'({busy, gen_en}), 32'b10);
            end
        end
        check("done_latency", 32'(done_cyc - ks), 32'd254);
        check("phase_toggles", 32'(toggles), 32'd4);
        @(posedge clk);
        #1;
        check("after_done", 32'({busy, done, gen_en}), 32'd0);
        check("cyc_cnt_hold", 32'(cyc_cnt), 32'd2);
        check("single_done", 32'(done_seen - done_before), 32'd1);

        // forced generator values: phase/cycle tracking table, then wrap
        @(negedge clk);
        gen_force = 1'b1;
        gen_force_val = 6'd30;
        div = 8'd3;
        num_cycles = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fstep(tbl[i].gout);
            check($sformatf("forced_%0d", i), 32'({phase, cyc_cnt}), 32'({tbl[i].ph, tbl[i].cnt}));
        end
        for (int p = 0; p < 14; p++) begin
            fstep(6'd63);
            fstep(6'd0);
            if (p == 12) check("cyc_cnt_15", 32'(cyc_cnt), 32'd15);
        end
        check("cyc_cnt_wrap", 32'({busy, cyc_cnt}), 32'h10);
        @(negedge clk);
        gen_force_val = 6'd30;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_after_wrap", 32'({busy, gen_en}), 32'd0);

        // asynchronous reset between edges mid-run
        done_before = done_seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fstep(6'd63);
        fstep(6'd0);
        fstep(6'd63);
        check("pre_reset_state", 32'({busy, phase, cyc_cnt}), 32'({1'b1, 1'b1, 4'd1}));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 32'({gen_en, gen_clr, phase, cyc_cnt, busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        gen_force_val = 6'd30;
        viol = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if ({gen_en, gen_clr, busy, done} != 4'b0000) viol++;
        end
        check("quiet_after_reset", 32'(viol), 32'd0);
        check("no_done_on_reset", 32'(done_seen - done_before), 32'd0);
        @(negedge clk);
        start = 1'b1;
        push("restart", 4'b0110);
        push("restart", 4'b0010);
        push("restart", 4'b0010);
        @(negedge clk);
        start = 1'b0;
        drain();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
